// File: rtl/thresh_presets_stepper.sv
// -----------------------------------------------------------------------------
// thresh_presets_stepper
//
// Purpose:
//   Keeps a registered index into a 16-entry table of {threshold, timer} pairs
//   and presents the selected pair to the ACL activity/inactivity
//   configuration logic. The index is moved by:
//     - up/down step buttons (debounced levels, rising edge = one step);
//     - a direct indexed load (e.g. from the UART command decoder).
//   At the ends of the active range the index either wraps or saturates.
//
// Optional feature:
//   THRESH_PRESETS_AUTOREPEAT_EN - when defined, a held button first waits
//   PARM_REPEAT_DLY cycles and then steps again every PARM_REPEAT_PER cycles.
//   When undefined, each press steps exactly once and no counter exists.
//
// Ports:
//   i_clk_20mhz     in   1           system clock
//   i_rst_20mhz     in   1           asynchronous, active-high reset
//   i_btn_up        in   1           debounced level, +1 on rising edge
//   i_btn_dn        in   1           debounced level, -1 on rising edge
//   i_load          in   1           single-cycle strobe, load i_load_idx
//   i_load_idx      in   4           index to load
//   o_value_enum    out  4           current index
//   o_value_thresh  out  PARM_VAL_W  threshold of the current entry
//   o_value_timer   out  PARM_VAL_W  timer of the current entry
//   o_value_changed out  1           one-cycle pulse with a new output value
//   o_load_err      out  1           one-cycle pulse after an out-of-range load
//
// All outputs come straight from flops; a request seen in cycle k is visible
// on every value output after the following clock edge.
// -----------------------------------------------------------------------------
module thresh_presets_stepper #(
  parameter int PARM_N_PRESETS = 10,
  parameter int PARM_VAL_W = 16,
  parameter int PARM_WRAP = 1,
  parameter int PARM_RST_IDX = 0,
  parameter logic [16*PARM_VAL_W-1:0] parm_presets_config_thresholds =
    {16{PARM_VAL_W'(32'd65000)}},
  parameter logic [16*PARM_VAL_W-1:0] parm_presets_config_timers =
    {16{PARM_VAL_W'(32'd65000)}},
  parameter int PARM_REPEAT_DLY = 20000000,
  parameter int PARM_REPEAT_PER = 4000000
) (
  input  logic                  i_clk_20mhz,
  input  logic                  i_rst_20mhz,
  input  logic                  i_btn_up,
  input  logic                  i_btn_dn,
  input  logic                  i_load,
  input  logic [3:0]            i_load_idx,
  output logic [3:0]            o_value_enum,
  output logic [PARM_VAL_W-1:0] o_value_thresh,
  output logic [PARM_VAL_W-1:0] o_value_timer,
  output logic                  o_value_changed,
  output logic                  o_load_err
);

  // Elaboration-time sanity check of the configuration.
  if ((PARM_N_PRESETS < 2) || (PARM_N_PRESETS > 16) ||
      (PARM_RST_IDX < 0) || (PARM_RST_IDX >= PARM_N_PRESETS) ||
      (PARM_VAL_W < 1) || (PARM_VAL_W > 32) ||
      (PARM_REPEAT_DLY < 1) || (PARM_REPEAT_PER < 1)) begin : g_param_check
    $error("thresh_presets_stepper: parameter out of range");
  end

  localparam logic [3:0] LAST_IDX_C  = 4'(PARM_N_PRESETS - 1);
  localparam logic [3:0] RST_IDX_C   = 4'(PARM_RST_IDX);
  localparam logic [4:0] N_PRESETS_C = 5'(PARM_N_PRESETS);

  // Button arbitration FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

`ifdef THRESH_PRESETS_AUTOREPEAT_EN
  localparam int REPEAT_MAX_C = (PARM_REPEAT_DLY > PARM_REPEAT_PER) ?
                                PARM_REPEAT_DLY : PARM_REPEAT_PER;
  localparam int CNT_W = $clog2(REPEAT_MAX_C + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DLY_LAST_C = CNT_W'(PARM_REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST_C = CNT_W'(PARM_REPEAT_PER - 1);
`endif

  // Table lookup: entry 0 sits in the most significant slice.
  function automatic logic [PARM_VAL_W-1:0] pick_entry(
    input logic [16*PARM_VAL_W-1:0] tbl,
    input logic [3:0]               idx
  );
    logic [PARM_VAL_W-1:0] val;
    val = {PARM_VAL_W{1'b0}};
    for (int i = 0; i < 16; i++) begin
      val = (idx == 4'(i)) ? tbl[(16-i)*PARM_VAL_W-1 -: PARM_VAL_W] : val;
    end
    return val;
  endfunction

  // Next index for an up step, honouring wrap/saturate at the top.
  function automatic logic [3:0] idx_inc(input logic [3:0] idx);
    logic [3:0] res;
    if (idx >= LAST_IDX_C) begin
      res = (PARM_WRAP != 0) ? 4'd0 : LAST_IDX_C;
    end else begin
      res = idx + 4'd1;
    end
    return res;
  endfunction

  // Next index for a down step, honouring wrap/saturate at the bottom.
  function automatic logic [3:0] idx_dec(input logic [3:0] idx);
    logic [3:0] res;
    if (idx == 4'd0) begin
      res = (PARM_WRAP != 0) ? LAST_IDX_C : 4'd0;
    end else begin
      res = idx - 4'd1;
    end
    return res;
  endfunction

  logic                  btn_up_q_r;
  logic                  btn_dn_q_r;
  logic [1:0]            state_r;
  logic                  owner_up_r;
  logic [3:0]            enum_r;
  logic [PARM_VAL_W-1:0] thresh_r;
  logic [PARM_VAL_W-1:0] timer_r;
  logic                  changed_r;
  logic                  load_err_r;

  logic                  rise_up_s;
  logic                  rise_dn_s;
  logic                  owner_lvl_s;
  logic                  other_rise_s;
  logic [1:0]            state_nxt_s;
  logic                  owner_up_nxt_s;
  logic                  step_up_s;
  logic                  step_dn_s;
  logic [3:0]            idx_nxt_s;
  logic                  changed_nxt_s;
  logic                  load_err_nxt_s;

`ifdef THRESH_PRESETS_AUTOREPEAT_EN
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_nxt_s;
`endif

  assign rise_up_s    = i_btn_up & ~btn_up_q_r;
  assign rise_dn_s    = i_btn_dn & ~btn_dn_q_r;
  // The owning button is the one whose rise last produced a step.
  assign owner_lvl_s  = owner_up_r ? i_btn_up : i_btn_dn;
  assign other_rise_s = owner_up_r ? rise_dn_s : rise_up_s;

  // Button arbitration: turns edges (and held time) into step requests.
  always_comb begin
    state_nxt_s    = state_r;
    owner_up_nxt_s = owner_up_r;
    step_up_s      = 1'b0;
    step_dn_s      = 1'b0;
`ifdef THRESH_PRESETS_AUTOREPEAT_EN
    cnt_nxt_s      = cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        // Simultaneous rises cancel each other and leave the FSM idle.
        if (rise_up_s ^ rise_dn_s) begin
          step_up_s      = rise_up_s;
          step_dn_s      = rise_dn_s;
          owner_up_nxt_s = rise_up_s;
          state_nxt_s    = ST_HOLD;
`ifdef THRESH_PRESETS_AUTOREPEAT_EN
          cnt_nxt_s      = CNT_ZERO_C;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (other_rise_s) begin
          // The other button takes over and restarts the hold period.
          step_up_s      = ~owner_up_r;
          step_dn_s      = owner_up_r;
          owner_up_nxt_s = ~owner_up_r;
          state_nxt_s    = ST_HOLD;
`ifdef THRESH_PRESETS_AUTOREPEAT_EN
          cnt_nxt_s      = CNT_ZERO_C;
`endif
        end else if (!owner_lvl_s) begin
          state_nxt_s = ST_IDLE;
`ifdef THRESH_PRESETS_AUTOREPEAT_EN
          cnt_nxt_s   = CNT_ZERO_C;
`endif
        end else begin
`ifdef THRESH_PRESETS_AUTOREPEAT_EN
          if (state_r == ST_HOLD) begin
            if (cnt_r == DLY_LAST_C) begin
              step_up_s   = owner_up_r;
              step_dn_s   = ~owner_up_r;
              state_nxt_s = ST_REPEAT;
              cnt_nxt_s   = CNT_ZERO_C;
            end else begin
              cnt_nxt_s = cnt_r + CNT_ONE_C;
            end
          end else begin
            if (cnt_r == PER_LAST_C) begin
              step_up_s = owner_up_r;
              step_dn_s = ~owner_up_r;
              cnt_nxt_s = CNT_ZERO_C;
            end else begin
              cnt_nxt_s = cnt_r + CNT_ONE_C;
            end
          end
`else
          state_nxt_s = state_r;
`endif
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Index update: load beats any step; saturated steps are not changes.
  always_comb begin
    idx_nxt_s      = enum_r;
    changed_nxt_s  = 1'b0;
    load_err_nxt_s = 1'b0;
    if (i_load) begin
      if ({1'b0, i_load_idx} < N_PRESETS_C) begin
        idx_nxt_s     = i_load_idx;
        changed_nxt_s = 1'b1;
      end else begin
        load_err_nxt_s = 1'b1;
      end
    end else if (step_up_s && !step_dn_s) begin
      idx_nxt_s     = idx_inc(enum_r);
      changed_nxt_s = (idx_inc(enum_r) != enum_r);
    end else if (step_dn_s && !step_up_s) begin
      idx_nxt_s     = idx_dec(enum_r);
      changed_nxt_s = (idx_dec(enum_r) != enum_r);
    end else begin
      idx_nxt_s = enum_r;
    end
  end

  // Button history and arbitration state; history resets high so a button
  // held through reset is not mistaken for a fresh press.
  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      btn_up_q_r <= 1'b1;
      btn_dn_q_r <= 1'b1;
      state_r    <= ST_IDLE;
      owner_up_r <= 1'b1;
    end else begin
      btn_up_q_r <= i_btn_up;
      btn_dn_q_r <= i_btn_dn;
      state_r    <= state_nxt_s;
      owner_up_r <= owner_up_nxt_s;
    end
  end

`ifdef THRESH_PRESETS_AUTOREPEAT_EN
  // Hold / repeat interval counter.
  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      cnt_r <= CNT_ZERO_C;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end
`endif

  // Registered outputs: index, table values and pulses move together.
  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      enum_r     <= RST_IDX_C;
      thresh_r   <= pick_entry(parm_presets_config_thresholds, RST_IDX_C);
      timer_r    <= pick_entry(parm_presets_config_timers, RST_IDX_C);
      changed_r  <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      enum_r     <= idx_nxt_s;
      thresh_r   <= pick_entry(parm_presets_config_thresholds, idx_nxt_s);
      timer_r    <= pick_entry(parm_presets_config_timers, idx_nxt_s);
      changed_r  <= changed_nxt_s;
      load_err_r <= load_err_nxt_s;
    end
  end

  assign o_value_enum    = enum_r;
  assign o_value_thresh  = thresh_r;
  assign o_value_timer   = timer_r;
  assign o_value_changed = changed_r;
  assign o_load_err      = load_err_r;

endmodule
